display_driver_arbiter: RTL and testbench
=========================================

// Module: display_driver_arbiter
// PURPOSE
//   Shares one shift_display_driver between NREQ display requesters, e.g. the channel
//   display, a volume overlay and a status/error indicator.
//   Each requester posts one {seg_data, digit_sel} digit write.
//   The arbiter grants one requester, latches its data, pulses the driver start, then
//   tracks the driver busy through to completion and returns done/err to that requester.
//   Sits between the display controllers and the single driver instance.
// PARAMETERS
//   NREQ         3      number of requesters (2..8)
//   FIXED_PRIO   0      0: round-robin; 1: fixed priority, lowest index wins
//   BUSY_TMO     64     cycles allowed in WAIT_BUSY before declaring timeout
//   TMO_W        7      width of the timeout counter; must hold BUSY_TMO
// PORTS
//   clk            in   1        system clock, 50 MHz
//   rst_n          in   1        asynchronous active-low reset
//   req            in   NREQ     per-requester write request (level)
//   req_seg_data   in   8*NREQ   packed segment byte; slice i = [8i+7:8i]
//   req_digit_sel  in   4*NREQ   packed digit select; slice i = [4i+3:4i]
//   ack            out  NREQ     one-hot 1-cycle pulse: request accepted, data latched
//   done           out  NREQ     one-hot 1-cycle pulse: driver finished the write
//   err            out  NREQ     one-hot 1-cycle pulse: driver timed out (no busy rise)
//   drv_seg_data   out  8        to driver seg_data; held stable while owned
//   drv_digit_sel  out  4        to driver digit_sel; held stable while owned
//   drv_start      out  1        to driver start; 1-cycle pulse
//   drv_busy       in   1        from driver busy
//   owner          out  3        index of current/last granted requester
//   active         out  1        1 while not in IDLE
// BEHAVIOUR
//   Reset values: ack/done/err = 0, drv_start = 0, drv_seg_data = 8'hFF (blank),
//     drv_digit_sel = 0, owner = 0, active = 0, rr pointer = 0, state = IDLE.
//   All outputs are registered.
//   FSM states:
//   - IDLE: if |req && !drv_busy, pick winner w, latch slice w into drv_*,
//     pulse ack[w], set owner=w, go to START. Otherwise stay.
//   - START: drv_start=1 for exactly this cycle, clear timeout counter, go to WAIT_BUSY.
//   - WAIT_BUSY: if drv_busy=1, go to WAIT_DONE.
//     Else if counter==BUSY_TMO-1, pulse err[owner] and go to IDLE.
//     Else increment the counter.
//   - WAIT_DONE: if drv_busy=0, pulse done[owner] and go to IDLE.
//   Latency: req high in cycle n with the arbiter idle gives ack in n+1 and drv_start
//     in n+2. The minimum turnaround, done to next ack, is 1 cycle.
//   Winner selection:
//   - Round-robin: first asserted req at or after rr pointer, wrapping NREQ-1 to 0.
//     The pointer becomes w+1 (mod NREQ) on ack.
//   - Fixed priority: lowest asserted index wins; the pointer is unused.
//   Requester rules:
//   - Data is sampled only in the ack cycle; the requester may change it afterwards.
//   - A requester must deassert req, or present new data, in the cycle after ack;
//     req still high then is treated as a new request.
//   - req is not required to stay high until grant; a dropped req is simply not picked.
//   Timing and corner cases:
//   - done and err are mutually exclusive per transaction; exactly one fires per ack.
//   - drv_busy already high in IDLE (driver owned from elsewhere or stale): no grant
//     until it falls.
//   - A req change during START/WAIT_* does not affect the current owner.
//   - Asynchronous reset mid-transaction aborts it: no done/err is issued and the
//     outputs return to their reset values.
//   - A BUSY_TMO counter wrap cannot occur: the counter saturates at the exit.
// STRUCTURE
//   display_pkg: state encoding localparams (IDLE, START, WAIT_BUSY, WAIT_DONE),
//     SEG_BLANK = 8'hFF, SEG_W = 8, DSEL_W = 4.
//   Sub-module rr_pick #(NREQ, FIXED_PRIO): combinational; inputs req and ptr; outputs
//     grant index and valid. It is the only natural split; the FSM and registers stay
//     in this module.
// TESTING
//   1. Reset with all req=0 -> drv_seg_data=8'hFF, all pulses 0, active=0.
//      A 20-cycle drv_busy stub is used for all scenarios.
//   2. Single request: req=3'b001, data 8'h86/4'd0 -> ack[0] in n+1, drv_start in n+2
//      with drv_seg_data=8'h86, done[0] after the busy fall.
//   3. Round-robin: all three req held high for 6 transactions -> owner order 0,1,2,0,1,2.
//      With FIXED_PRIO=1 -> owner 0 six times.
//   4. Timeout: stub never raises busy -> err[owner] exactly BUSY_TMO cycles after
//      drv_start, no done, next ack possible 1 cycle later.
//   5. busy held high at grant time: req=3'b010 -> no ack until drv_busy=0, then ack[1].
//   6. Reset asserted in WAIT_DONE -> outputs go to reset values immediately, no done.
//      The first request after reset is served normally with pointer 0.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg -- shared constants for the display driver arbiter.
//   State encoding for the arbiter FSM (kept as plain localparams so the
//   encoding is visible to legacy tools and waveform viewers), the blank
//   segment pattern and the field widths of one digit write.
package display_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam int SEG_W  = 8;
  localparam int DSEL_W = 4;
  localparam int IDX_W  = 3;  // requester index / owner width, covers up to 8 requesters

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

endpackage : display_pkg

// File: rtl/rr_pick.sv
// rr_pick -- combinational winner selection among NREQ requesters.
//   FIXED_PRIO = 0 : first asserted request at or after ptr_i, wrapping.
//   FIXED_PRIO = 1 : lowest asserted index wins; ptr_i is ignored.
// Ports:
//   req_i    [NREQ-1:0]  request vector
//   ptr_i    [IDX_W-1:0] round-robin start position (0..NREQ-1)
//   grant_o  [IDX_W-1:0] winning index (0 when valid_o is low)
//   valid_o              at least one request is asserted
module rr_pick
  import display_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int FIXED_PRIO = 0
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             valid_o
);

  localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDX_W-1:0] rr_idx;
  logic             rr_vld;
  logic [IDX_W-1:0] fp_idx;
  logic             fp_vld;

  // Both pickers are always built; the parameter only selects the result.
  // Loops run from the highest candidate down so the preferred candidate is
  // the last one written.
  always_comb begin
    int cand;
    cand   = 0;
    rr_idx = '0;
    rr_vld = 1'b0;
    fp_idx = '0;
    fp_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[SEL_W'(i)]) begin
        fp_vld = 1'b1;
        fp_idx = IDX_W'(i);
      end
    end
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = (int'(ptr_i) + off) % NREQ;
      if (req_i[SEL_W'(cand)]) begin
        rr_vld = 1'b1;
        rr_idx = IDX_W'(cand);
      end
    end
  end

  assign grant_o = (FIXED_PRIO != 0) ? fp_idx : rr_idx;
  assign valid_o = (FIXED_PRIO != 0) ? fp_vld : rr_vld;

endmodule : rr_pick

// File: rtl/display_driver_arbiter.sv
// display_driver_arbiter -- shares one shift display driver between NREQ
// requesters. One digit write is granted at a time: the winner's data is
// latched onto drv_seg_data/drv_digit_sel, drv_start is pulsed, and the
// driver busy is tracked to completion (done) or timeout (err).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req [NREQ]            per-requester write request (level)
//   req_seg_data [8*NREQ] packed segment bytes, slice i = [8i+7:8i]
//   req_digit_sel[4*NREQ] packed digit selects, slice i = [4i+3:4i]
//   ack/done/err [NREQ]   one-hot single-cycle pulses to the requesters
//   drv_seg_data, drv_digit_sel, drv_start  to the driver
//   drv_busy              from the driver
//   owner [3]             current / last granted requester
//   active                high while a transaction is in progress
module display_driver_arbiter
  import display_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int FIXED_PRIO = 0,
  parameter int BUSY_TMO   = 64,
  parameter int TMO_W      = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [SEG_W*NREQ-1:0]  req_seg_data,
  input  logic [DSEL_W*NREQ-1:0] req_digit_sel,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        err,
  output logic [SEG_W-1:0]       drv_seg_data,
  output logic [DSEL_W-1:0]      drv_digit_sel,
  output logic                   drv_start,
  input  logic                   drv_busy,
  output logic [IDX_W-1:0]       owner,
  output logic                   active
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [DSEL_W-1:0] dsel_q, dsel_d;
  logic              start_q, start_d;
  logic              active_q, active_d;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;
  logic [NREQ-1:0]   pick_oh;
  logic [NREQ-1:0]   owner_oh;
  logic [SEG_W-1:0]  pick_seg;
  logic [DSEL_W-1:0] pick_dsel;
  logic [IDX_W-1:0]  ptr_next;

  rr_pick #(
    .NREQ       (NREQ),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (pick_idx),
    .valid_o (pick_vld)
  );

  assign pick_oh  = NREQ'(1) << pick_idx;
  assign owner_oh = NREQ'(1) << owner_q;
  assign ptr_next = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

  // Constant-base slice mux for the winner's data.
  always_comb begin
    pick_seg  = '0;
    pick_dsel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_seg  = req_seg_data[i*SEG_W +: SEG_W];
        pick_dsel = req_digit_sel[i*DSEL_W +: DSEL_W];
      end
    end
  end

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    tmo_d   = tmo_q;
    seg_d   = seg_q;
    dsel_d  = dsel_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        // A busy driver here is owned elsewhere or stale: hold off the grant.
        if (pick_vld && !drv_busy) begin
          ack_d   = pick_oh;
          owner_d = pick_idx;
          seg_d   = pick_seg;
          dsel_d  = pick_dsel;
          if (FIXED_PRIO == 0) ptr_d = ptr_next;
          state_d = START;
        end
      end
      START: begin
        start_d = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (drv_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // Counter stops at the exit value, so it never wraps.
          err_d   = owner_oh;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!drv_busy) begin
          done_d  = owner_oh;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      tmo_q    <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      seg_q    <= SEG_BLANK;
      dsel_q   <= '0;
      start_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      tmo_q    <= tmo_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      seg_q    <= seg_d;
      dsel_q   <= dsel_d;
      start_q  <= start_d;
      active_q <= active_d;
    end
  end

  assign ack           = ack_q;
  assign done          = done_q;
  assign err           = err_q;
  assign drv_seg_data  = seg_q;
  assign drv_digit_sel = dsel_q;
  assign drv_start     = start_q;
  assign owner         = owner_q;
  assign active        = active_q;

endmodule : display_driver_arbiter

// File: tb/tb_display_driver_arbiter.sv
// Self-checking bench for display_driver_arbiter: directed vector table,
// multi-cycle corner sequences, and a randomized run against a
// transaction-level reference model.
module tb_display_driver_arbiter;

  localparam int NREQ     = 3;
  localparam int BUSY_TMO = 64;
  localparam int STUB_LEN = 20;
  // Cycle offsets from the ack cycle, derived from the stub: busy rises the
  // cycle after drv_start and stays high STUB_LEN cycles.
  localparam int DONE_OFS = STUB_LEN + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [23:0] seg_in = '0;
  logic [11:0] dsel_in = '0;

  logic [2:0] d_ack, d_done, d_err, d_owner;
  logic [7:0] d_seg;
  logic [3:0] d_dsel;
  logic       d_start, d_busy, d_active;
  logic [2:0] f_ack, f_done, f_err, f_owner;
  logic [7:0] f_seg;
  logic [3:0] f_dsel;
  logic       f_start, f_busy, f_active;

  logic stub_en = 1'b1;
  logic force_busy = 1'b0;
  int   d_cnt, f_cnt;

  int total = 0;
  int bad = 0;

  always #10 clk = ~clk;

  display_driver_arbiter #(.NREQ(NREQ), .FIXED_PRIO(0), .BUSY_TMO(BUSY_TMO), .TMO_W(7)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_seg_data(seg_in), .req_digit_sel(dsel_in),
    .ack(d_ack), .done(d_done), .err(d_err), .drv_seg_data(d_seg), .drv_digit_sel(d_dsel),
    .drv_start(d_start), .drv_busy(d_busy), .owner(d_owner), .active(d_active)
  );

  display_driver_arbiter #(.NREQ(NREQ), .FIXED_PRIO(1), .BUSY_TMO(BUSY_TMO), .TMO_W(7)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(req), .req_seg_data(seg_in), .req_digit_sel(dsel_in),
    .ack(f_ack), .done(f_done), .err(f_err), .drv_seg_data(f_seg), .drv_digit_sel(f_dsel),
    .drv_start(f_start), .drv_busy(f_busy), .owner(f_owner), .active(f_active)
  );

  // Driver stubs: busy high for STUB_LEN cycles starting the cycle after start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_cnt <= 0;
    else if (d_start && stub_en) d_cnt <= STUB_LEN;
    else if (d_cnt != 0) d_cnt <= d_cnt - 1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) f_cnt <= 0;
    else if (f_start && stub_en) f_cnt <= STUB_LEN;
    else if (f_cnt != 0) f_cnt <= f_cnt - 1;
  end
  assign d_busy = force_busy | (d_cnt != 0);
  assign f_busy = force_busy | (f_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int oh2idx(input logic [2:0] v);
    for (int i = 0; i < NREQ; i++) if (v == 3'(1 << i)) return i;
    return -1;
  endfunction

  // Round-robin rule: first asserted request at or after p, wrapping.
  function automatic int model_pick(input logic [2:0] r, input int p);
    for (int off = 0; off < NREQ; off++)
      if (((r >> ((p + off) % NREQ)) & 3'd1) != 0) return (p + off) % NREQ;
    return -1;
  endfunction

  typedef struct {
    logic [2:0] req;
    logic [7:0] seg;
    logic [3:0] dsel;
    int         exp_w;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int w;
    bit got_err, got_done;
    int d_own[6];
    int f_own[6];
    int d_n, f_n, last_done, turn_bad;
    int ptr_m, owner_m, w_m, t_ack, free_at;
    logic [7:0]  seg_m;
    logic [3:0]  dsel_m;
    logic [2:0]  r;
    logic [13:0] obs, exp_obs;
    logic [2:0]  e_ack, e_done;

    // Sequential table from reset; expected winners follow the rr pointer.
    vecs[0] = '{3'b001, 8'h86, 4'd0, 0};
    vecs[1] = '{3'b100, 8'hC0, 4'd3, 2};
    vecs[2] = '{3'b010, 8'hA4, 4'd1, 1};
    vecs[3] = '{3'b011, 8'hB0, 4'd2, 0};
    vecs[4] = '{3'b101, 8'h99, 4'd7, 2};
    vecs[5] = '{3'b110, 8'h92, 4'd9, 1};

    // 1. reset state
    repeat (2) tick();
    check("rst_seg", 32'(d_seg), 32'h00FF);
    check("rst_pulses", 32'({d_ack, d_done, d_err, d_start}), 32'h0);
    check("rst_active_owner", 32'({d_active, d_owner, d_dsel}), 32'h0);
    rst_n = 1'b1;
    tick();
    check("idle_after_rst", 32'({d_active, d_seg, d_start}), 32'({1'b0, 8'hFF, 1'b0}));

    // 2. vector table: single transactions with latency and data checks
    for (int v = 0; v < 6; v++) begin
      w = vecs[v].exp_w;
      req = vecs[v].req;
      seg_in = 24'($urandom);
      dsel_in = 12'($urandom);
      seg_in[8*w +: 8] = vecs[v].seg;
      dsel_in[4*w +: 4] = vecs[v].dsel;
      tick();
      check($sformatf("v%0d_ack", v), 32'(d_ack), 32'(1 << w));
      check($sformatf("v%0d_owner", v), 32'(d_owner), 32'(w));
      req = '0;
      seg_in = ~seg_in;
      dsel_in = ~dsel_in;
      tick();
      check($sformatf("v%0d_start", v), 32'({d_start, d_seg, d_dsel}),
            32'({1'b1, vecs[v].seg, vecs[v].dsel}));
      n = 0; got_err = 0;
      while (n < 40 && d_done == 0) begin
        tick(); n++;
        if (d_err != 0) got_err = 1;
      end
      check($sformatf("v%0d_done", v), 32'(d_done), 32'(1 << w));
      check($sformatf("v%0d_done_lat", v), 32'(n), 32'(DONE_OFS - 1));
      check($sformatf("v%0d_no_err", v), 32'(got_err), 32'h0);
    end

    // 3. all requests held high: rr order vs fixed priority, 1-cycle turnaround
    do_reset();
    req = 3'b111;
    d_n = 0; f_n = 0; last_done = -10; turn_bad = 0;
    for (int c = 0; c < 250 && (d_n < 6 || f_n < 6); c++) begin
      tick();
      if (d_done != 0) last_done = c;
      if (d_ack != 0 && d_n < 6) begin
        if (d_n > 0 && c - last_done != 1) turn_bad++;
        d_own[d_n] = oh2idx(d_ack); d_n++;
      end
      if (f_ack != 0 && f_n < 6) begin
        f_own[f_n] = oh2idx(f_ack); f_n++;
      end
    end
    req = '0;
    check("rr_count", 32'(d_n), 32'd6);
    check("fp_count", 32'(f_n), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_owner%0d", i), 32'(d_own[i]), 32'(i % 3));
      check($sformatf("fp_owner%0d", i), 32'(f_own[i]), 32'd0);
    end
    check("turnaround", 32'(turn_bad), 32'd0);

    // 4. timeout: busy never rises
    stub_en = 1'b0;
    do_reset();
    req = 3'b010;
    tick();
    check("tmo_ack", 32'(d_ack), 32'b010);
    tick();
    check("tmo_start", 32'(d_start), 32'd1);
    n = 0; got_done = 0;
    while (n < BUSY_TMO + 20 && d_err == 0) begin
      tick(); n++;
      if (d_done != 0) got_done = 1;
    end
    check("tmo_err", 32'(d_err), 32'b010);
    check("tmo_err_lat", 32'(n), 32'(BUSY_TMO));
    check("tmo_no_done", 32'({got_done, d_done}), 32'h0);
    tick();
    check("tmo_reack", 32'(d_ack), 32'b010);
    req = '0;
    stub_en = 1'b1;

    // 5. busy already high in IDLE blocks the grant
    force_busy = 1'b1;
    do_reset();
    req = 3'b010;
    n = 0;
    repeat (10) begin
      tick();
      if (d_ack != 0) n++;
    end
    check("busy_no_ack", 32'(n), 32'd0);
    force_busy = 1'b0;
    tick();
    check("busy_late_ack", 32'(d_ack), 32'b010);
    req = '0;
    n = 0;
    while (n < 40 && d_done == 0) begin tick(); n++; end
    check("busy_done", 32'(d_done), 32'b010);

    // 6. reset during WAIT_DONE
    do_reset();
    req = 3'b001;
    tick();
    req = '0;
    tick();
    repeat (5) tick();
    check("mid_busy", 32'({d_busy, d_active}), 32'b11);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vals", 32'({d_active, d_owner, d_seg, d_dsel, d_start}), 32'({1'b0, 3'd0, 8'hFF, 4'd0, 1'b0}));
    check("mid_rst_pulses", 32'({d_ack, d_done, d_err}), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    n = 0;
    repeat (30) begin
      tick();
      if (d_done != 0 || d_err != 0) n++;
    end
    check("mid_no_done", 32'(n), 32'd0);
    req = 3'b011;
    tick();
    check("post_rst_ptr", 32'({d_ack, d_owner}), 32'({3'b001, 3'd0}));
    req = '0;
    n = 0;
    while (n < 40 && d_done == 0) begin tick(); n++; end
    check("post_rst_done", 32'(d_done), 32'b001);

    // 7. randomized run against the transaction-level model
    do_reset();
    ptr_m = 0; owner_m = 0; w_m = 0; t_ack = -100; free_at = 0;
    seg_m = '0; dsel_m = '0;
    for (int k = 0; k < 600; k++) begin
      if (k == t_ack) owner_m = w_m;
      e_ack  = (k == t_ack) ? 3'(1 << w_m) : 3'b000;
      e_done = (k == t_ack + DONE_OFS) ? 3'(1 << w_m) : 3'b000;
      exp_obs = {e_ack, e_done, 3'b000, 1'(k == t_ack + 1),
                 1'(k >= t_ack && k < t_ack + DONE_OFS), 3'(owner_m)};
      obs = {d_ack, d_done, d_err, d_start, d_active, d_owner};
      check($sformatf("rand_obs_c%0d", k), 32'(obs), 32'(exp_obs));
      if (k == t_ack + 1)
        check($sformatf("rand_data_c%0d", k), 32'({d_seg, d_dsel}), 32'({seg_m, dsel_m}));
      r = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      req = r;
      seg_in = 24'($urandom);
      dsel_in = 12'($urandom);
      if (k >= free_at && r != 0) begin
        w_m = model_pick(r, ptr_m);
        ptr_m = (w_m + 1) % NREQ;
        t_ack = k + 1;
        free_at = k + 1 + DONE_OFS;
        seg_m = seg_in[8*w_m +: 8];
        dsel_m = dsel_in[4*w_m +: 4];
      end
      tick();
    end
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_display_driver_arbiter
